// File: rtl/collatz_pkg.sv
// Shared types and default sizes for the Collatz orbit engine.
package collatz_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/collatz_step.sv
// One Collatz iteration: next iterate, the 3n+1 value, step increment and overflow flag.
module collatz_step
  import collatz_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] iter_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic [WIDTH+1:0] t_o,
  output logic [1:0]       inc_o,
  output logic             ovf_o
);

  logic [WIDTH+1:0] iter_ext;

  always_comb begin
    iter_ext = {2'b00, iter_i};
    // Two extra bits hold 3n+1 for any WIDTH-bit n without wrapping.
    t_o      = (iter_ext << 1) + iter_ext + {{(WIDTH+1){1'b0}}, 1'b1};
    ovf_o    = iter_i[0] & (|t_o[WIDTH+1:WIDTH]);
    next_o   = {1'b0, iter_i[WIDTH-1:1]};
    inc_o    = 2'd1;
    if (iter_i[0]) begin
      if (mode_i) begin
        next_o = t_o[WIDTH:1];
        inc_o  = 2'd2;
      end else begin
        next_o = t_o[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/collatz_core.sv
// Iterative Collatz orbit engine: counts steps, tracks the peak iterate, flags overflow/timeout.
module collatz_core
  import collatz_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     number,
  input  logic                 shortcut,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] orbit_len,
  output logic [WIDTH-1:0]     path_record,
  output logic                 overflow,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     iter_q, iter_d;
  logic                 mode_q, mode_d;
  logic [CNT_WIDTH-1:0] orbit_q, orbit_d;
  logic [WIDTH-1:0]     path_q, path_d;
  logic                 ovf_q, ovf_d;
  logic                 to_q, to_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     step_next;
  logic [WIDTH+1:0]     step_t;
  logic [1:0]           step_inc;
  logic                 step_ovf;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [WIDTH+1:0]     peak_cand;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .iter_i (iter_q),
    .mode_i (mode_q),
    .next_o (step_next),
    .t_o    (step_t),
    .inc_o  (step_inc),
    .ovf_o  (step_ovf)
  );

  // Carry out of the widened sum means the counter cannot absorb this step.
  function automatic logic [CNT_WIDTH:0] cnt_add(input logic [CNT_WIDTH-1:0] cnt,
                                                 input logic [1:0] inc);
    return {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
  endfunction

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    mode_d    = mode_q;
    orbit_d   = orbit_q;
    path_d    = path_q;
    ovf_d     = ovf_q;
    to_d      = to_q;
    done_d    = 1'b0;
    cnt_sum   = cnt_add(orbit_q, step_inc);
    // Odd steps peak at 3n+1 even when shortcut mode halves it afterwards.
    peak_cand = iter_q[0] ? step_t : {2'b00, step_next};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          iter_d  = number;
          path_d  = number;
          orbit_d = '0;
          ovf_d   = 1'b0;
          to_d    = 1'b0;
          mode_d  = shortcut;
          state_d = RUN;
        end
      end
      RUN: begin
        if (iter_q[WIDTH-1:1] == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (step_ovf) begin
          ovf_d   = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_sum[CNT_WIDTH]) begin
          to_d    = 1'b1;
          orbit_d = CNT_MAX;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          iter_d  = step_next;
          orbit_d = cnt_sum[CNT_WIDTH-1:0];
          if (peak_cand > {2'b00, path_q}) path_d = peak_cand[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
      mode_q  <= 1'b0;
      orbit_q <= '0;
      path_q  <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
      orbit_q <= orbit_d;
      path_q  <= path_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign orbit_len   = orbit_q;
  assign path_record = path_q;
  assign overflow    = ovf_q;
  assign timeout     = to_q;

endmodule
